// File: rtl/pcie_latency_tracker.sv
// PCIe round-trip latency tracker: per-tag TX timestamp table, RX latency pipeline
// and running min/max/sum/count, orphan and duplicate statistics.
module pcie_latency_tracker #(
   parameter int unsigned TS_WIDTH  = 64,
   parameter int unsigned TAG_WIDTH = 10,
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned SUM_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stat_clear,
   input  logic [TS_WIDTH-1:0]  ts_now,
   input  logic                 tx_valid,
   input  logic [TAG_WIDTH-1:0] tx_tag,
   input  logic                 rx_valid,
   input  logic [TAG_WIDTH-1:0] rx_tag,
   output logic                 lat_valid,
   output logic [TAG_WIDTH-1:0] lat_tag,
   output logic [TS_WIDTH-1:0]  lat_value,
   output logic                 lat_orphan,
   output logic [TS_WIDTH-1:0]  lat_min,
   output logic [TS_WIDTH-1:0]  lat_max,
   output logic [SUM_WIDTH-1:0] lat_sum,
   output logic [CNT_WIDTH-1:0] lat_count,
   output logic [CNT_WIDTH-1:0] orphan_count,
   output logic [CNT_WIDTH-1:0] dup_count,
   output logic [CNT_WIDTH-1:0] outstanding
);

   localparam int unsigned DEPTH = 2**TAG_WIDTH;

   logic [DEPTH-1:0]     valid_q;
   logic [TS_WIDTH-1:0]  ts_ram [DEPTH];
   logic [TS_WIDTH-1:0]  rd_q;

   logic                 s1_valid;
   logic                 s1_hit;
   logic [TAG_WIDTH-1:0] s1_tag;
   logic [TS_WIDTH-1:0]  s1_ts;

   logic                 tx_was_valid;
   logic                 rx_hit;
   logic                 same_tag;
   logic                 dup_event;
   logic                 out_inc;
   logic                 out_dec;

   logic                 stat_hit;
   logic                 stat_miss;
   logic [SUM_WIDTH:0]   sum_ext;
   logic [SUM_WIDTH-1:0] sum_next;

   // An rx on the same tag consumes the old entry, so the tx is a re-install, not a dup.
   always_comb begin
      tx_was_valid = valid_q[tx_tag];
      rx_hit       = valid_q[rx_tag];
      same_tag     = tx_valid && rx_valid && (tx_tag == rx_tag);
      dup_event    = tx_valid && tx_was_valid && !same_tag;
      out_inc      = tx_valid && (!tx_was_valid || same_tag);
      out_dec      = rx_valid && rx_hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         if (rx_valid) valid_q[rx_tag] <= 1'b0;
         if (tx_valid) valid_q[tx_tag] <= 1'b1;
      end
   end

   // Read-first RAM: same-cycle rx sees the old entry, earlier writes are already visible.
   always_ff @(posedge clk) begin
      if (tx_valid) ts_ram[tx_tag] <= ts_now;
      if (rx_valid) rd_q <= ts_ram[rx_tag];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_hit   <= 1'b0;
         s1_tag   <= '0;
         s1_ts    <= '0;
      end else begin
         s1_valid <= rx_valid;
         if (rx_valid) begin
            s1_hit <= rx_hit;
            s1_tag <= rx_tag;
            s1_ts  <= ts_now;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_valid  <= 1'b0;
         lat_tag    <= '0;
         lat_value  <= '0;
         lat_orphan <= 1'b0;
      end else begin
         lat_valid  <= s1_valid;
         lat_orphan <= s1_valid && !s1_hit;
         if (s1_valid) begin
            lat_tag   <= s1_tag;
            lat_value <= s1_hit ? (s1_ts - rd_q) : '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else if (out_inc && !out_dec) begin
         outstanding <= outstanding + CNT_WIDTH'(1);
      end else if (out_dec && !out_inc) begin
         outstanding <= outstanding - CNT_WIDTH'(1);
      end
   end

   always_comb begin
      stat_hit  = lat_valid && !lat_orphan;
      stat_miss = lat_valid && lat_orphan;
      sum_ext   = {1'b0, lat_sum} + (SUM_WIDTH+1)'(lat_value);
      sum_next  = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
   end

   // stat_clear takes priority over any coincident statistics update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_min      <= '1;
         lat_max      <= '0;
         lat_sum      <= '0;
         lat_count    <= '0;
         orphan_count <= '0;
         dup_count    <= '0;
      end else if (stat_clear) begin
         lat_min      <= '1;
         lat_max      <= '0;
         lat_sum      <= '0;
         lat_count    <= '0;
         orphan_count <= '0;
         dup_count    <= '0;
      end else begin
         if (stat_hit) begin
            if (lat_value < lat_min) lat_min <= lat_value;
            if (lat_value > lat_max) lat_max <= lat_value;
            lat_sum <= sum_next;
            if (lat_count != '1) lat_count <= lat_count + CNT_WIDTH'(1);
         end
         if (stat_miss && (orphan_count != '1)) orphan_count <= orphan_count + CNT_WIDTH'(1);
         if (dup_event && (dup_count != '1)) dup_count <= dup_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pcie_latency_tracker.sv
// Directed bench for pcie_latency_tracker: hit, wrap, orphan, dup, hazards,
// streaming statistics, stat_clear and reset mid-flight.
module tb_pcie_latency_tracker;

   logic        clk = 1'b0;
   logic        rst;
   logic        stat_clear;
   logic [63:0] ts_now;
   logic        tx_valid;
   logic [9:0]  tx_tag;
   logic        rx_valid;
   logic [9:0]  rx_tag;
   logic        lat_valid;
   logic [9:0]  lat_tag;
   logic [63:0] lat_value;
   logic        lat_orphan;
   logic [63:0] lat_min;
   logic [63:0] lat_max;
   logic [63:0] lat_sum;
   logic [31:0] lat_count;
   logic [31:0] orphan_count;
   logic [31:0] dup_count;
   logic [31:0] outstanding;

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   always #5 clk = ~clk;

   pcie_latency_tracker #(
      .TS_WIDTH  (64),
      .TAG_WIDTH (10),
      .CNT_WIDTH (32),
      .SUM_WIDTH (64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stat_clear   (stat_clear),
      .ts_now       (ts_now),
      .tx_valid     (tx_valid),
      .tx_tag       (tx_tag),
      .rx_valid     (rx_valid),
      .rx_tag       (rx_tag),
      .lat_valid    (lat_valid),
      .lat_tag      (lat_tag),
      .lat_value    (lat_value),
      .lat_orphan   (lat_orphan),
      .lat_min      (lat_min),
      .lat_max      (lat_max),
      .lat_sum      (lat_sum),
      .lat_count    (lat_count),
      .orphan_count (orphan_count),
      .dup_count    (dup_count),
      .outstanding  (outstanding)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total_cnt++;
      assert (observed === expected) pass_cnt++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   task automatic chk_result(input string tag, input logic [9:0] t, input logic [63:0] v, input logic orph);
      chk({tag, "_valid"}, 64'(lat_valid), 64'd1);
      chk({tag, "_tag"}, 64'(lat_tag), 64'(t));
      chk({tag, "_value"}, lat_value, v);
      chk({tag, "_orphan"}, 64'(lat_orphan), 64'(orph));
   endtask

   initial begin
      rst = 1'b1; stat_clear = 1'b0; ts_now = '0;
      tx_valid = 1'b0; tx_tag = '0; rx_valid = 1'b0; rx_tag = '0;
      repeat (3) tick();
      chk("rst_lat_valid", 64'(lat_valid), 64'd0);
      chk("rst_lat_value", lat_value, 64'd0);
      chk("rst_lat_min", lat_min, ONES);
      chk("rst_lat_max", lat_max, 64'd0);
      chk("rst_lat_sum", lat_sum, 64'd0);
      chk("rst_lat_count", 64'(lat_count), 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      rst = 1'b0;
      tick();

      // basic hit: tag 5, 100 -> 350
      tx_valid = 1'b1; tx_tag = 10'd5; ts_now = 64'd100;
      tick();
      tx_valid = 1'b0;
      chk("basic_outstanding_1", 64'(outstanding), 64'd1);
      rx_valid = 1'b1; rx_tag = 10'd5; ts_now = 64'd350;
      tick();
      rx_valid = 1'b0;
      chk("basic_no_early_valid", 64'(lat_valid), 64'd0);
      tick();
      chk_result("basic", 10'd5, 64'd250, 1'b0);
      tick();
      chk("basic_strobe_one_cycle", 64'(lat_valid), 64'd0);
      chk("basic_min", lat_min, 64'd250);
      chk("basic_max", lat_max, 64'd250);
      chk("basic_sum", lat_sum, 64'd250);
      chk("basic_count", 64'(lat_count), 64'd1);
      chk("basic_outstanding_0", 64'(outstanding), 64'd0);

      // counter wrap: tag 1, 2^64-10 -> 20
      tx_valid = 1'b1; tx_tag = 10'd1; ts_now = 64'hFFFF_FFFF_FFFF_FFF6;
      tick();
      tx_valid = 1'b0;
      rx_valid = 1'b1; rx_tag = 10'd1; ts_now = 64'd20;
      tick();
      rx_valid = 1'b0;
      tick();
      chk_result("wrap", 10'd1, 64'd30, 1'b0);
      tick();
      chk("wrap_min", lat_min, 64'd30);
      chk("wrap_sum", lat_sum, 64'd280);

      // orphan: tag 7 never issued
      rx_valid = 1'b1; rx_tag = 10'd7; ts_now = 64'd500;
      tick();
      rx_valid = 1'b0;
      tick();
      chk_result("orphan", 10'd7, 64'd0, 1'b1);
      tick();
      chk("orphan_count", 64'(orphan_count), 64'd1);
      chk("orphan_lat_count", 64'(lat_count), 64'd2);

      // duplicate tx on tag 3: 10 then 40, rx at 100
      tx_valid = 1'b1; tx_tag = 10'd3; ts_now = 64'd10;
      tick();
      ts_now = 64'd40;
      tick();
      tx_valid = 1'b0;
      chk("dup_count", 64'(dup_count), 64'd1);
      chk("dup_outstanding", 64'(outstanding), 64'd1);
      rx_valid = 1'b1; rx_tag = 10'd3; ts_now = 64'd100;
      tick();
      rx_valid = 1'b0;
      tick();
      chk_result("dup", 10'd3, 64'd60, 1'b0);
      tick();

      // same-cycle tx/rx on tag 9
      tx_valid = 1'b1; tx_tag = 10'd9; ts_now = 64'd0;
      tick();
      rx_valid = 1'b1; rx_tag = 10'd9; ts_now = 64'd50;
      tick();
      tx_valid = 1'b0; rx_valid = 1'b0;
      chk("same_dup_unchanged", 64'(dup_count), 64'd1);
      chk("same_outstanding", 64'(outstanding), 64'd1);
      tick();
      chk_result("same_first", 10'd9, 64'd50, 1'b0);
      rx_valid = 1'b1; rx_tag = 10'd9; ts_now = 64'd80;
      tick();
      rx_valid = 1'b0;
      tick();
      chk_result("same_second", 10'd9, 64'd30, 1'b0);
      tick();
      chk("same_outstanding_0", 64'(outstanding), 64'd0);

      // rx one cycle after tx on tag 2
      tx_valid = 1'b1; tx_tag = 10'd2; ts_now = 64'd1000;
      tick();
      tx_valid = 1'b0;
      rx_valid = 1'b1; rx_tag = 10'd2; ts_now = 64'd1007;
      tick();
      rx_valid = 1'b0;
      tick();
      chk_result("fwd_n1", 10'd2, 64'd7, 1'b0);
      tick();

      // rx two cycles after tx on tag 4
      tx_valid = 1'b1; tx_tag = 10'd4; ts_now = 64'd2000;
      tick();
      tx_valid = 1'b0;
      tick();
      rx_valid = 1'b1; rx_tag = 10'd4; ts_now = 64'd2003;
      tick();
      rx_valid = 1'b0;
      tick();
      chk_result("fwd_n2", 10'd4, 64'd3, 1'b0);
      tick();

      // overwrite of tag 4 the cycle before its rx
      tx_valid = 1'b1; tx_tag = 10'd4; ts_now = 64'd3000;
      tick();
      ts_now = 64'd3010;
      tick();
      tx_valid = 1'b0;
      rx_valid = 1'b1; rx_tag = 10'd4; ts_now = 64'd3015;
      tick();
      rx_valid = 1'b0;
      tick();
      chk_result("fwd_overwrite", 10'd4, 64'd5, 1'b0);
      tick();
      chk("acc_count", 64'(lat_count), 64'd8);
      chk("acc_sum", lat_sum, 64'd435);
      chk("acc_min", lat_min, 64'd3);
      chk("acc_max", lat_max, 64'd250);
      chk("acc_dup", 64'(dup_count), 64'd2);
      chk("acc_orphan", 64'(orphan_count), 64'd1);
      chk("acc_outstanding", 64'(outstanding), 64'd0);

      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      chk("clr1_min", lat_min, ONES);
      chk("clr1_count", 64'(lat_count), 64'd0);
      chk("clr1_dup", 64'(dup_count), 64'd0);

      // streaming: tag i issued at ts i, completed at ts 2i+1 -> latency i+1
      for (int i = 0; i < 1024; i++) begin
         tx_valid = 1'b1; tx_tag = 10'(i); ts_now = 64'(i);
         tick();
      end
      tx_valid = 1'b0;
      chk("stream_outstanding_full", 64'(outstanding), 64'd1024);
      for (int i = 0; i <= 1024; i++) begin
         if (i < 1024) begin
            rx_valid = 1'b1; rx_tag = 10'(i); ts_now = 64'(2 * i + 1);
         end else begin
            rx_valid = 1'b0;
         end
         tick();
         if (i >= 1) begin
            chk("stream_value", lat_value, 64'(i));
            chk("stream_tag", 64'(lat_tag), 64'(i - 1));
         end
      end
      tick();
      chk("stream_min", lat_min, 64'd1);
      chk("stream_max", lat_max, 64'd1024);
      chk("stream_sum", lat_sum, 64'd524800);
      chk("stream_count", 64'(lat_count), 64'd1024);
      chk("stream_outstanding", 64'(outstanding), 64'd0);

      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      chk("clr2_min", lat_min, ONES);
      chk("clr2_max", lat_max, 64'd0);
      chk("clr2_sum", lat_sum, 64'd0);
      chk("clr2_count", 64'(lat_count), 64'd0);
      chk("clr2_orphan", 64'(orphan_count), 64'd0);

      // reset with rx results in flight
      for (int i = 10; i <= 12; i++) begin
         tx_valid = 1'b1; tx_tag = 10'(i); ts_now = 64'd0;
         tick();
      end
      tx_valid = 1'b0;
      for (int i = 10; i <= 12; i++) begin
         rx_valid = 1'b1; rx_tag = 10'(i); ts_now = 64'd5;
         tick();
      end
      rx_valid = 1'b0;
      chk("inflight_first_result", 64'(lat_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_valid", 64'(lat_valid), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_valid", 64'(lat_valid), 64'd0);
      end
      chk("post_rst_outstanding", 64'(outstanding), 64'd0);
      chk("post_rst_count", 64'(lat_count), 64'd0);
      chk("post_rst_sum", lat_sum, 64'd0);
      chk("post_rst_min", lat_min, ONES);
      chk("post_rst_orphan", 64'(orphan_count), 64'd0);
      chk("post_rst_dup", 64'(dup_count), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pcie_latency_tracker.md
Name: pcie_latency_tracker

Overview:
- Parametrised successor to the single-channel timestamp BRAM used for PCIe round-trip latency checks.
- Stores the TX-side timestamp per outstanding tag. On RX match, computes latency in hardware and emits a per-transaction latency result.
- Maintains running min/max/sum/count statistics, plus orphan and duplicate counters, for VIO/ILA readout.
- Sits between TX_ENGINE (issue events), RX_ENGINE (completion events) and the free-running latency counter.

Parameters:
- TS_WIDTH, 64, width of the timestamp and the latency value.
- TAG_WIDTH, 10, tag width; table depth is 2**TAG_WIDTH.
- CNT_WIDTH, 32, width of lat_count, orphan_count, dup_count and outstanding.
- SUM_WIDTH, 64, width of the latency accumulator.

Ports:
- clk  in  1  single clock (250 MHz)
- rst  in  1  asynchronous active-high reset
- stat_clear  in  1  synchronous clear of statistics only (user/VIO reset)
- ts_now  in  TS_WIDTH  free-running latency counter
- tx_valid  in  1  request issued; capture timestamp for tx_tag
- tx_tag  in  TAG_WIDTH  tag of issued request
- rx_valid  in  1  completion received for rx_tag
- rx_tag  in  TAG_WIDTH  tag of completion
- lat_valid  out  1  one-cycle strobe: latency result valid
- lat_tag  out  TAG_WIDTH  tag of result
- lat_value  out  TS_WIDTH  measured latency in clk cycles
- lat_orphan  out  1  with lat_valid: rx_tag was not outstanding; lat_value=0
- lat_min  out  TS_WIDTH  minimum latency since clear
- lat_max  out  TS_WIDTH  maximum latency since clear
- lat_sum  out  SUM_WIDTH  saturating latency sum
- lat_count  out  CNT_WIDTH  saturating count of matched completions
- orphan_count  out  CNT_WIDTH  saturating count of orphans
- dup_count  out  CNT_WIDTH  saturating count of tx on an already-outstanding tag
- outstanding  out  CNT_WIDTH  number of tags currently outstanding

Behaviour:

Reset (async):
- All outputs 0, except lat_min = all ones.
- Valid bitmap (2**TAG_WIDTH flops) cleared.
- Timestamp RAM contents are don't-care.

Timestamp table:
- RAM of depth 2**TAG_WIDTH × TS_WIDTH.
- Separate valid bitmap held in flops.
- tx_valid in cycle N: ram[tx_tag] <= ts_now(N); valid[tx_tag] <= 1.
- If valid[tx_tag] is already 1 (ignoring an rx on the same tag in cycle N): dup_count++; entry overwritten with the new timestamp.

RX pipeline (fixed latency 2):
- Cycle N: rx_valid sampled; ts_now(N), rx_tag and valid[rx_tag] registered; RAM read issued; valid[rx_tag] <= 0.
- Cycle N+1: RAM data returned.
- Cycle N+2: lat_valid=1, lat_tag=rx_tag.
  - Hit: lat_value = ts_now(N) − stored, modulo 2**TS_WIDTH. Counter wrap is handled by the unsigned subtraction.
  - Miss: lat_orphan=1, lat_value=0, orphan_count++.
- Back-to-back rx on every cycle is supported; no stalls, no backpressure.

Ordering and hazards:
- Same cycle, tx and rx on the same tag: rx consumes the old entry (hit if it was valid); tx then installs the new entry; valid ends at 1; no dup counted.
- rx in cycle N on a tag written by tx in N−1 or N−2 must observe the new timestamp. Use write-first RAM or a bypass; verify explicitly.

Statistics:
- Updated in cycle N+3 from the N+2 result, on hits only.
- lat_min = min(lat_min, v); lat_max = max(lat_max, v).
- lat_sum += v, saturating at all ones.
- lat_count += 1, saturating.
- orphan_count and dup_count saturate at all ones.
- outstanding: +1 on tx to a non-valid tag, −1 on an rx hit. Both in the same cycle on different tags: net 0.

stat_clear:
- Clears lat_min (to all ones), lat_max, lat_sum, lat_count, orphan_count and dup_count in the next cycle.
- Does not touch the table or outstanding.
- A stats update coinciding with stat_clear is dropped (clear wins).
- Results already in the pipeline still emit on lat_valid.

Reset mid-operation:
- In-flight results are discarded; no lat_valid follows reset deassertion.

Test Plan:
- tx tag 5 at ts_now=100; rx tag 5 at ts_now=350 → two cycles later lat_valid=1, lat_tag=5, lat_value=250; after stats update lat_min=lat_max=lat_sum=250, lat_count=1, outstanding=0.
- Wrap: tx tag 1 at ts_now=2**64−10; rx at ts_now=20 → lat_value=30.
- Orphan: rx tag 7 with nothing outstanding → lat_orphan=1, lat_value=0, orphan_count=1, lat_count unchanged. A duplicate tx tag 3 at ts 10 and then ts 40, with rx at ts 100 → dup_count=1, lat_value=60.
- Same-cycle tx/rx on tag 9 (earlier tx at ts 0, both events at ts 50); second rx at ts 80 → first result 50, second result 30. Separately, rx one cycle after tx on tag 2 → hit with the fresh timestamp.
- Streaming: 1024 tags issued, then 1024 consecutive rx cycles with latencies 1..1024 → lat_min=1, lat_max=1024, lat_sum=524800, lat_count=1024, outstanding=0. Then stat_clear → lat_min=all ones and other stats 0.
- Assert rst while 3 rx are in flight → no lat_valid after deassertion, outstanding=0, all counters 0.
